// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit and its lane aligner.
package lsu_pkg;

  localparam int unsigned MemBytesDefault = 32;

  typedef enum logic [1:0] {
    SizeByte    = 2'b00,
    SizeHalf    = 2'b01,
    SizeWord    = 2'b10,
    SizeIllegal = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRd   = 2'b01,
    StWr   = 2'b10,
    StResp = 2'b11
  } lsu_state_e;

  function automatic logic [32:0] access_bytes(lsu_size_e size);
    case (size)
      SizeHalf: access_bytes = 33'd2;
      SizeWord: access_bytes = 33'd4;
      default:  access_bytes = 33'd1;
    endcase
  endfunction

endpackage

// File: rtl/byte_lane_align.sv
// Big-endian lane extraction with sign/zero extension, and sub-word store merging.
module byte_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  lsu_size_e   size_i,
  input  logic        signed_i,
  input  logic [31:0] store_data_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merged_o
);

  logic [4:0]  shamt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;

  assign shamt = {offset_i, 3'b000};

  always_comb begin
    case (offset_i)
      2'd0:    byte_sel = word_i[31:24];
      2'd1:    byte_sel = word_i[23:16];
      2'd2:    byte_sel = word_i[15:8];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = offset_i[1] ? word_i[15:0] : word_i[31:16];

    load_data_o = word_i;
    lane_mask   = '1;
    lane_data   = store_data_i;
    case (size_i)
      SizeByte: begin
        load_data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
        lane_mask   = 32'hFF00_0000 >> shamt;
        lane_data   = {store_data_i[7:0], 24'h0} >> shamt;
      end
      SizeHalf: begin
        load_data_o = {{16{signed_i & half_sel[15]}}, half_sel};
        lane_mask   = 32'hFFFF_0000 >> shamt;
        lane_data   = {store_data_i[15:0], 16'h0} >> shamt;
      end
      default: ;
    endcase
    // Only the target lanes take store data; the rest keep the sampled word.
    merged_o = (word_i & ~lane_mask) | (lane_data & lane_mask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-request load/store unit: one access at a time, read-modify-write for sub-word stores.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MemBytesDefault
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        respError,
  output logic [31:0] address,
  output logic [31:0] writeData,
  output logic        memRead,
  output logic        memWrite,
  input  logic [31:0] readData
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  lsu_size_e   size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        req_ready_q, req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;

  lsu_size_e   req_size;
  logic [32:0] last_byte;
  logic        req_error;
  logic [31:0] load_data;
  logic [31:0] merged;

  assign req_size  = lsu_size_e'(reqSize);
  // 33-bit sum so addresses near 2^32 cannot wrap into range.
  assign last_byte = {1'b0, reqAddress} + access_bytes(req_size) - 33'd1;
  assign req_error = (req_size == SizeIllegal)
                   | ((req_size == SizeHalf) & reqAddress[0])
                   | ((req_size == SizeWord) & (|reqAddress[1:0]))
                   | (last_byte >= 33'(MEM_BYTES));

  byte_lane_align u_align (
    .word_i      (readData),
    .offset_i    (addr_q[1:0]),
    .size_i      (size_q),
    .signed_i    (signed_q),
    .store_data_i(wdata_q),
    .load_data_o (load_data),
    .merged_o    (merged)
  );

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_data_d  = '0;
    resp_error_d = 1'b0;
    address_d    = '0;
    write_data_d = '0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (reqValid && req_ready_q) begin
          write_d  = reqWrite;
          size_d   = req_size;
          signed_d = reqSigned;
          addr_d   = reqAddress;
          wdata_d  = reqWriteData;
          if (req_error) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (reqWrite && (req_size == SizeWord)) begin
            state_d      = StWr;
            mem_write_d  = 1'b1;
            address_d    = {reqAddress[31:2], 2'b00};
            write_data_d = reqWriteData;
          end else begin
            state_d    = StRd;
            mem_read_d = 1'b1;
            address_d  = {reqAddress[31:2], 2'b00};
          end
        end
      end
      StRd: begin
        if (write_q) begin
          state_d      = StWr;
          mem_write_d  = 1'b1;
          address_d    = {addr_q[31:2], 2'b00};
          write_data_d = merged;
        end else begin
          state_d      = StResp;
          resp_valid_d = 1'b1;
          resp_data_d  = load_data;
        end
      end
      StWr: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      size_q       <= SizeByte;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_error_q <= 1'b0;
      address_q    <= '0;
      write_data_q <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
    end
  end

  assign reqReady  = req_ready_q;
  assign respValid = resp_valid_q;
  assign respData  = resp_data_q;
  assign respError = resp_error_q;
  assign address   = address_q;
  assign writeData = write_data_q;
  assign memRead   = mem_read_q;
  assign memWrite  = mem_write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: vector table, response scoreboard, and hand-written reset/back-to-back cases.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqSigned = 1'b0;
  logic [31:0] reqAddress = '0;
  logic [31:0] reqWriteData = '0;
  logic        respValid;
  logic [31:0] respData;
  logic        respError;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] readData;

  load_store_unit #(.MEM_BYTES(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .reqValid    (reqValid),
    .reqReady    (reqReady),
    .reqWrite    (reqWrite),
    .reqSize     (reqSize),
    .reqSigned   (reqSigned),
    .reqAddress  (reqAddress),
    .reqWriteData(reqWriteData),
    .respValid   (respValid),
    .respData    (respData),
    .respError   (respError),
    .address     (address),
    .writeData   (writeData),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .readData    (readData)
  );

  always #5 clock = ~clock;

  logic [31:0] mem [8] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_000A, 32'h0, 32'h0, 32'h0,
                           32'h0, 32'h0};
  assign readData = memRead ? mem[address[4:2]] : 32'h0;
  always @(posedge clock) if (memWrite) mem[address[4:2]] <= writeData;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [31:0] exp_wdata;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_rd = 0;
  int n_wr = 0;
  int n_resp = 0;
  logic [31:0] last_rd_addr = '0;
  logic [31:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic sg, logic [31:0] a,
                              logic [31:0] wd, logic [31:0] ed, logic ee, int lat, int nr,
                              int nw, logic [31:0] ewd);
    vec_t v;
    v.wr = wr; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd;
    v.exp_data = ed; v.exp_err = ee; v.exp_lat = lat; v.exp_rd = nr; v.exp_wr = nw;
    v.exp_wdata = ewd;
    return v;
  endfunction

  function automatic exp_t mk_exp(logic [31:0] d, logic e, int lat, int acc);
    exp_t x;
    x.data = d; x.err = e; x.lat = lat; x.acc = acc;
    return x;
  endfunction

  always @(negedge clock) begin
    check("rd_wr_exclusive", {63'b0, memRead & memWrite}, 64'd0);
    if (memRead) begin
      n_rd++;
      last_rd_addr = address;
    end
    if (memWrite) begin
      n_wr++;
      last_wr_addr = address;
      last_wr_data = writeData;
    end
    if (respValid) begin
      n_resp++;
      if (sb.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_data", respData, e.data);
        check("resp_error", respError, e.err);
        check("resp_latency", cyc - e.acc + 1, e.lat);
      end
    end else begin
      check("resp_quiet", {respError, respData}, 64'd0);
    end
    if (reqReady) begin
      check("idle_address", address, 64'd0);
      check("idle_writedata", writeData, 64'd0);
      check("idle_strobes", {memRead, memWrite}, 64'd0);
    end
  end

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clock); #1;
    end
    check("drain_timeout", sb.size(), 64'd0);
    sb.delete();
  endtask

  task automatic issue(input vec_t v);
    int waited;
    @(negedge clock); #1;
    n_rd = 0;
    n_wr = 0;
    reqWrite = v.wr; reqSize = v.size; reqSigned = v.sgn;
    reqAddress = v.addr; reqWriteData = v.wdata;
    reqValid = 1'b1;
    waited = 0;
    while (!reqReady && waited < 20) begin
      @(negedge clock); #1;
      waited++;
    end
    check("accept_ready", reqReady, 64'd1);
    if (reqReady) begin
      sb.push_back(mk_exp(v.exp_data, v.exp_err, v.exp_lat, cyc + 1));
      @(posedge clock); #1;
    end
    reqValid = 1'b0;
    drain();
    check("read_count", n_rd, v.exp_rd);
    check("write_count", n_wr, v.exp_wr);
    if (v.exp_rd > 0) check("read_addr", last_rd_addr, {v.addr[31:2], 2'b00});
    if (v.exp_wr > 0) begin
      check("write_addr", last_wr_addr, {v.addr[31:2], 2'b00});
      check("write_data", last_wr_data, v.exp_wdata);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    logic saw;
    int wr0;
    int rv0;

    //      wr sz sg addr           wdata         exp_data      err lat rd wr exp_wdata
    vecs.push_back(mk(0, 2, 0, 32'd8,  32'h0,         32'h0000000A, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'd5,  32'h12345680,  32'h0,        0, 3, 1, 1, 32'h00800001));
    vecs.push_back(mk(0, 0, 1, 32'd5,  32'h0,         32'hFFFFFF80, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'd5,  32'h0,         32'h00000080, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 2, 0, 32'd0,  32'hDEADBEEF,  32'h0,        0, 2, 0, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 1, 1, 32'd2,  32'h0,         32'hFFFFBEEF, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'd3,  32'h0,         32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2, 0, 32'd32, 32'h0,         32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'd0,  32'h0,         32'h0000DEAD, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'd6,  32'hFFFF1234,  32'h0,        0, 3, 1, 1, 32'h00801234));
    vecs.push_back(mk(0, 2, 0, 32'd4,  32'h0,         32'h00801234, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 3, 0, 32'd0,  32'h0,         32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 2, 0, 32'd2,  32'h0,         32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'd31, 32'h000000AB,  32'h0,        0, 3, 1, 1, 32'h000000AB));
    vecs.push_back(mk(0, 0, 1, 32'd31, 32'h0,         32'hFFFFFFAB, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'd30, 32'h0,         32'h000000AB, 0, 2, 1, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'd32, 32'h1,         32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 0, 0, 32'hFFFFFFFF, 32'h1,   32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 1, 32'd29, 32'h1,         32'h0,        1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'd1,  32'h0,         32'h000000AD, 0, 2, 1, 0, 32'h0));

    // Reset: everything low, reqReady rises on the first edge after release.
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_ready", reqReady, 64'd0);
    check("rst_strobes", {memRead, memWrite, respValid, respError}, 64'd0);
    check("rst_address", address, 64'd0);
    check("rst_writedata", writeData, 64'd0);
    check("rst_respdata", respData, 64'd0);
    reset_n = 1'b1;
    #1;
    check("rel_ready_before_edge", reqReady, 64'd0);
    @(negedge clock); #1;
    check("rel_ready_after_edge", reqReady, 64'd1);

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

    // Back-to-back loads with reqValid held high.
    @(negedge clock); #1;
    reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0; reqAddress = 32'd8;
    reqValid = 1'b1;
    check("b2b_ready_first", reqReady, 64'd1);
    sb.push_back(mk_exp(32'h0000000A, 1'b0, 2, cyc + 1));
    @(posedge clock); #1;
    reqAddress = 32'd4;
    waited = 0;
    saw = 1'b0;
    while (waited < 10) begin
      @(negedge clock); #1;
      waited++;
      if (respValid) saw = 1'b1;
      if (reqReady) break;
    end
    check("b2b_resp_before_ready", saw, 64'd1);
    check("b2b_ready_wait", waited, 64'd3);
    sb.push_back(mk_exp(32'h00801234, 1'b0, 2, cyc + 1));
    @(posedge clock); #1;
    reqValid = 1'b0;
    drain();

    // Reset asserted during the read phase of a byte store at 9.
    @(negedge clock); #1;
    wr0 = n_wr;
    rv0 = n_resp;
    reqWrite = 1'b1; reqSize = 2'b00; reqSigned = 1'b0; reqAddress = 32'd9;
    reqWriteData = 32'h00000055;
    reqValid = 1'b1;
    check("rmw_rst_ready", reqReady, 64'd1);
    @(posedge clock); #1;
    reqValid = 1'b0;
    check("rmw_rst_rd_active", memRead, 64'd1);
    #1;
    reset_n = 1'b0;
    #1;
    check("rmw_rst_rd_dropped", memRead, 64'd0);
    check("rmw_rst_outputs", {reqReady, memWrite, respValid, respError}, 64'd0);
    check("rmw_rst_address", address, 64'd0);
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock); #1;
    check("rmw_rst_ready_after", reqReady, 64'd1);
    check("rmw_rst_no_write", n_wr - wr0, 64'd0);
    check("rmw_rst_no_resp", n_resp - rv0, 64'd0);
    check("rmw_rst_word8", mem[2], 64'h0000000A);
    issue(mk(0, 2, 0, 32'd8, 32'h0, 32'h0000000A, 0, 2, 1, 0, 32'h0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 32, giving the addressable byte range 0..MEM_BYTES-1 of the attached memory.
REQ-002 SHALL have port clock, in, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, in, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have port reqValid, in, 1, datapath request present.
REQ-005 SHALL have port reqReady, out, 1, unit accepts a request this cycle.
REQ-006 SHALL have port reqWrite, in, 1, 1 = store, 0 = load.
REQ-007 SHALL have port reqSize, in, 2, access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 SHALL have port reqSigned, in, 1, loads sign-extend when 1 and zero-extend when 0.
REQ-009 SHALL have port reqAddress, in, 32, byte address.
REQ-010 SHALL have port reqWriteData, in, 32, store data, right-aligned.
REQ-011 SHALL have port respValid, out, 1, one-cycle completion pulse.
REQ-012 SHALL have port respData, out, 32, load result, right-aligned; 0 for stores and errors.
REQ-013 SHALL have port respError, out, 1, valid with respValid; 1 = request rejected.
REQ-014 SHALL have port address, out, 32, word-aligned memory address.
REQ-015 SHALL have port writeData, out, 32, memory write word.
REQ-016 SHALL have port memRead, out, 1, memory read strobe.
REQ-017 SHALL have port memWrite, out, 1, memory write strobe.
REQ-018 SHALL have port readData, in, 32, memory read word; valid by the rising edge ending a memRead cycle.

Function
REQ-019 SHALL use big-endian byte order: byte offset k maps to word bits [31-8k -: 8], half offset 0 maps to [31:16], and half offset 2 maps to [15:0].
REQ-020 SHALL implement the FSM IDLE -> {RD, WR, RESP}, RD -> {RESP, WR}, WR -> RESP, RESP -> IDLE.
REQ-021 SHALL drive reqReady = 1 only in IDLE; acceptance occurs on an edge where reqValid & reqReady, and all req* fields are captured then.
REQ-022 SHALL route accepted requests as follows: errored -> RESP; load -> RD; word store -> WR; byte/half store -> RD, then WR (read-modify-write).
REQ-023 SHALL flag an error for size 11, an odd half address, a word address not divisible by 4, or any accessed byte at or above MEM_BYTES.
REQ-024 SHALL, for an errored request, produce no memRead/memWrite cycles.
REQ-025 SHALL, in RD, drive memRead = 1 for exactly one cycle with address = {reqAddress[31:2], 2'b00}, and sample readData on the closing edge.
REQ-026 SHALL, in WR, drive memWrite = 1 for exactly one cycle with address and writeData stable for the whole cycle.
REQ-027 SHALL form writeData for a sub-word store as the sampled word with only the target lanes replaced.
REQ-028 SHALL never assert memRead and memWrite in the same cycle.
REQ-029 SHALL register all outputs; in IDLE, address, writeData, memRead and memWrite are 0.
REQ-030 SHALL, in RESP, drive respValid = 1 for exactly one cycle, with respData/respError held only during that cycle and 0 otherwise.
REQ-031 SHALL meet these latencies from the accept edge to respValid high: load 2 cycles; word store 2; sub-word store 3; error 1.
REQ-032 SHALL ignore reqValid outside IDLE and never queue requests.

Reset
REQ-033 SHALL, while reset_n = 0, immediately force state IDLE, reqReady = 0, and all other outputs to 0.
REQ-034 SHALL discard any in-flight request on reset, with no memWrite and no respValid; reqReady = 1 on the first edge after release.

Structure
REQ-035 SHALL place the size encodings, FSM state encoding and MEM_BYTES default in shared package lsu_pkg.
REQ-036 SHALL place lane extraction/sign-extension and store merging in one combinational sub-module, byte_lane_align.

Verification
The bench memory SHALL be preloaded with word0 = 0x00000001, word4 = 0x00000001 and word8 = 0x0000000A.
REQ-037 SHALL verify a word load at address 8: one memRead at address 8, then respValid 2 cycles after accept with respData = 0x0000000A.
REQ-038 SHALL verify a byte store of 0x80 at address 5: RD at 4, then WR at 4 with writeData = 0x00800001; a signed byte load at 5 then returns 0xFFFFFF80 and an unsigned one 0x00000080.
REQ-039 SHALL verify a word store of 0xDEADBEEF at address 0: one memWrite, no memRead; a signed half load at 2 then returns 0xFFFFBEEF.
REQ-040 SHALL verify that a half load at 3 and a word load at 32 each give respError = 1 and respData = 0 one cycle after accept, with no memRead/memWrite.
REQ-041 SHALL verify that reset_n low during the RD of a byte store at address 9 drops memRead asynchronously, with no memWrite, no respValid, and word8 still 0x0000000A.
REQ-042 SHALL verify that reqValid held high for two back-to-back loads accepts the second only after respValid of the first (reqReady low meanwhile).
